// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Controller state: normal sequencing, or the single post-trap flush cycle
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_t;

  // Stage indices, oldest stage has the highest index
  localparam int unsigned STG_FCH = 0;
  localparam int unsigned STG_DEC = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WRB = 4;
  localparam int unsigned NUM_STG = 5;

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating event counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  // Count register; holds at maximum instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing controller: stage enables, bubbles, kills,
// per-stage valid bits and stall performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fch_valid,
  input  logic             dec_stall,
  input  logic             dec_load_use,
  input  logic             dec_csr_use,
  input  logic             exe_busy,
  input  logic             exe_redirect,
  input  logic             mem_wait,
  input  logic             wrb_trap,
  output logic             fch_enb,
  output logic             dec_enb,
  output logic             exe_enb,
  output logic             mem_enb,
  output logic             wrb_enb,
  output logic             dec_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wrb_valid,
  output logic             fch_redirect,
  output logic             trap_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] csr_use_cnt
);

  pipe_state_t state, state_nxt;

  logic [NUM_STG-1:0] enb;
  logic dec_valid_nxt, exe_valid_nxt, mem_valid_nxt, wrb_valid_nxt;
  logic stall_inc, load_use_inc, csr_use_inc;

  logic busy_hit, stall_hit, redir_hit, trap_hit;

  // Hazard inputs only count when the stage they belong to holds a live instruction
  assign busy_hit  = exe_busy && exe_valid;
  assign stall_hit = dec_stall && dec_valid;
  assign redir_hit = exe_redirect && exe_valid && !mem_wait && !exe_busy;
  assign trap_hit  = wrb_trap && wrb_valid && !mem_wait;

  assign fch_enb = enb[STG_FCH];
  assign dec_enb = enb[STG_DEC];
  assign exe_enb = enb[STG_EXE];
  assign mem_enb = enb[STG_MEM];
  assign wrb_enb = enb[STG_WRB];

  // State register and per-stage valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      dec_valid <= 1'b0;
      exe_valid <= 1'b0;
      mem_valid <= 1'b0;
      wrb_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      dec_valid <= dec_valid_nxt;
      exe_valid <= exe_valid_nxt;
      mem_valid <= mem_valid_nxt;
      wrb_valid <= wrb_valid_nxt;
    end
  end

  // Next state, enables, valid-bit updates, redirect pulses and counter events
  always_comb begin
    state_nxt     = state;
    enb           = '1;
    dec_valid_nxt = fch_valid;
    exe_valid_nxt = dec_valid;
    mem_valid_nxt = exe_valid;
    wrb_valid_nxt = mem_valid;
    fch_redirect  = 1'b0;
    trap_redirect = 1'b0;
    stall_inc     = 1'b0;
    load_use_inc  = 1'b0;
    csr_use_inc   = 1'b0;

    case (state)
      ST_FLUSH: begin
        // Trap vector fetch cycle: everything loads, nothing becomes live
        dec_valid_nxt = 1'b0;
        exe_valid_nxt = 1'b0;
        mem_valid_nxt = 1'b0;
        wrb_valid_nxt = 1'b0;
        state_nxt     = ST_RUN;
      end
      default: begin
        if (mem_wait) begin
          enb           = '0;
          dec_valid_nxt = dec_valid;
          exe_valid_nxt = exe_valid;
          mem_valid_nxt = mem_valid;
          wrb_valid_nxt = wrb_valid;
          stall_inc     = 1'b1;
        end else if (trap_hit) begin
          trap_redirect = 1'b1;
          dec_valid_nxt = 1'b0;
          exe_valid_nxt = 1'b0;
          mem_valid_nxt = 1'b0;
          wrb_valid_nxt = 1'b0;
          state_nxt     = ST_FLUSH;
        end else if (busy_hit) begin
          enb[STG_FCH]  = 1'b0;
          enb[STG_DEC]  = 1'b0;
          enb[STG_EXE]  = 1'b0;
          dec_valid_nxt = dec_valid;
          exe_valid_nxt = exe_valid;
          mem_valid_nxt = 1'b0;
          stall_inc     = 1'b1;
        end else if (redir_hit) begin
          // Kill the two younger instructions; EXE still moves on to MEM
          fch_redirect  = 1'b1;
          dec_valid_nxt = 1'b0;
          exe_valid_nxt = 1'b0;
        end else if (stall_hit) begin
          enb[STG_FCH]  = 1'b0;
          enb[STG_DEC]  = 1'b0;
          dec_valid_nxt = dec_valid;
          exe_valid_nxt = 1'b0;
          stall_inc     = 1'b1;
          load_use_inc  = dec_load_use;
          csr_use_inc   = dec_csr_use;
        end
      end
    endcase
  end

  // Performance counters
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (load_use_inc),
    .count (load_use_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_csr_use_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (csr_use_inc),
    .count (csr_use_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a 4-bit counter build.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic fch_valid, dec_stall, dec_load_use, dec_csr_use;
  logic exe_busy, exe_redirect, mem_wait, wrb_trap;
  logic fch_enb, dec_enb, exe_enb, mem_enb, wrb_enb;
  logic dec_valid, exe_valid, mem_valid, wrb_valid;
  logic fch_redirect, trap_redirect;
  logic [CNT_W-1:0] stall_cnt, load_use_cnt, csr_use_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fch_valid    (fch_valid),
    .dec_stall    (dec_stall),
    .dec_load_use (dec_load_use),
    .dec_csr_use  (dec_csr_use),
    .exe_busy     (exe_busy),
    .exe_redirect (exe_redirect),
    .mem_wait     (mem_wait),
    .wrb_trap     (wrb_trap),
    .fch_enb      (fch_enb),
    .dec_enb      (dec_enb),
    .exe_enb      (exe_enb),
    .mem_enb      (mem_enb),
    .wrb_enb      (wrb_enb),
    .dec_valid    (dec_valid),
    .exe_valid    (exe_valid),
    .mem_valid    (mem_valid),
    .wrb_valid    (wrb_valid),
    .fch_redirect (fch_redirect),
    .trap_redirect(trap_redirect),
    .stall_cnt    (stall_cnt),
    .load_use_cnt (load_use_cnt),
    .csr_use_cnt  (csr_use_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enables packed as {fch,dec,exe,mem,wrb}
  task automatic chk_en(input string tag, input logic [4:0] exp);
    chk({tag, " enb"}, 32'({fch_enb, dec_enb, exe_enb, mem_enb, wrb_enb}), 32'(exp));
  endtask

  // Valids packed as {dec,exe,mem,wrb}
  task automatic chk_v(input string tag, input logic [3:0] exp);
    chk({tag, " valid"}, 32'({dec_valid, exe_valid, mem_valid, wrb_valid}), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int s, input int l, input int c);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(s));
    chk({tag, " load_use_cnt"}, 32'(load_use_cnt), 32'(l));
    chk({tag, " csr_use_cnt"}, 32'(csr_use_cnt), 32'(c));
  endtask

  task automatic chk_pulse(input string tag, input logic fr, input logic tr);
    chk({tag, " pulses"}, 32'({fch_redirect, trap_redirect}), 32'({fr, tr}));
  endtask

  // Advance one clock; inputs change and registered outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    fch_valid = 0; dec_stall = 0; dec_load_use = 0; dec_csr_use = 0;
    exe_busy = 0; exe_redirect = 0; mem_wait = 0; wrb_trap = 0;
    step(); step();

    // Reset state
    chk_v("reset", 4'b0000);
    chk_en("reset", 5'b11111);
    chk_pulse("reset", 1'b0, 1'b0);
    chk_cnt("reset", 0, 0, 0);
    reset = 1'b0;

    // Fill from FCH
    fch_valid = 1'b1;
    #1;
    chk_en("fill", 5'b11111);
    step(); chk_v("fill c1", 4'b1000);
    step(); chk_v("fill c2", 4'b1100);
    step(); chk_v("fill c3", 4'b1110);
    step(); chk_v("fill c4", 4'b1111);
    chk_en("fill c4", 5'b11111);
    chk_cnt("fill", 0, 0, 0);

    // Load-use stall inserts a bubble into EXE
    dec_stall = 1; dec_load_use = 1;
    #1;
    chk_en("load_use", 5'b00111);
    step();
    dec_stall = 0; dec_load_use = 0;
    chk_v("load_use", 4'b1011);
    chk_cnt("load_use", 1, 1, 0);

    // Refill to a full pipe
    step(); chk_v("refill c1", 4'b1101);
    step(); chk_v("refill c2", 4'b1110);
    step(); chk_v("refill c3", 4'b1111);

    // mem_wait dominates stall and redirect
    mem_wait = 1; dec_stall = 1; exe_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_en("mem_wait", 5'b00000);
      chk_pulse("mem_wait", 1'b0, 1'b0);
      step();
    end
    chk_v("mem_wait", 4'b1111);
    chk_cnt("mem_wait", 4, 1, 0);

    // Redirect overrides dec_stall
    mem_wait = 0; dec_load_use = 1;
    #1;
    chk_pulse("redirect", 1'b1, 1'b0);
    chk_en("redirect", 5'b11111);
    step();
    dec_stall = 0; dec_load_use = 0;
    chk_v("redirect", 4'b0011);
    chk_cnt("redirect", 4, 1, 0);
    // Redirect ignored with EXE empty
    #1;
    chk_pulse("redirect dead", 1'b0, 1'b0);
    step();
    exe_redirect = 0;
    chk_v("post redirect", 4'b1001);
    step(); chk_v("run c1", 4'b1100);
    step(); chk_v("run c2", 4'b1110);
    step(); chk_v("run c3", 4'b1111);

    // Trap held under mem_wait fires once mem_wait drops, beating redirect
    wrb_trap = 1; mem_wait = 1;
    #1;
    chk_pulse("trap held", 1'b0, 1'b0);
    step();
    mem_wait = 0; exe_redirect = 1;
    #1;
    chk_pulse("trap", 1'b0, 1'b1);
    step();
    wrb_trap = 0; exe_redirect = 0;
    chk_v("trap", 4'b0000);
    chk_en("flush", 5'b11111);
    chk_pulse("flush", 1'b0, 1'b0);
    step();
    chk_v("flush", 4'b0000);
    step();
    chk_v("after flush", 4'b1000);
    chk_cnt("trap", 5, 1, 0);

    // CSR-use stall
    dec_stall = 1; dec_csr_use = 1;
    step();
    dec_stall = 0; dec_csr_use = 0;
    chk_v("csr_use", 4'b1000);
    chk_cnt("csr_use", 6, 1, 1);

    // Saturation with a 4-bit counter
    mem_wait = 1;
    for (int i = 0; i < 20; i++) step();
    chk("saturate stall_cnt", 32'(stall_cnt), 32'd15);
    chk_v("saturate", 4'b1000);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk_cnt("async reset", 0, 0, 0);
    chk_v("async reset", 4'b0000);
    mem_wait = 0;
    step();
    reset = 1'b0;
    #1;
    chk_en("after reset", 5'b11111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core (FCH, DEC, EXE, MEM, WRB). It turns hazard, busy and redirect conditions into per-stage advance enables, bubble insertion and kill decisions, and keeps per-stage valid bits. It consumes the DEC-stage hazard outputs (stall, load-use, CSR-use) and provides stall/bubble performance counters. It owns no datapath registers; stage registers load only when their enable is high.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fch_valid  in  1  FCH holds a valid fetched instruction
- dec_stall  in  1  DEC operand hazard; DEC must hold
- dec_load_use  in  1  DEC stall caused by a load in EXE
- dec_csr_use  in  1  DEC stall caused by a CSRRx in EXE
- exe_busy  in  1  multi-cycle EXE operation not yet complete
- exe_redirect  in  1  taken branch/jump resolved in EXE
- mem_wait  in  1  data memory not ready; MEM must hold
- wrb_trap  in  1  exception/interrupt taken at WRB
- fch_enb, dec_enb, exe_enb, mem_enb, wrb_enb  out  1 each  stage register load enable
- dec_valid, exe_valid, mem_valid, wrb_valid  out  1 each  stage holds a live instruction
- fch_redirect  out  1  one-cycle pulse: FCH loads branch target
- trap_redirect  out  1  one-cycle pulse: FCH loads trap vector
- stall_cnt, load_use_cnt, csr_use_cnt  out  CNT_W each  saturating event counters

## Operation
- Freeze priority in RUN state (highest first):
  - mem_wait: all enables 0; no valid bit changes.
  - exe_busy && exe_valid: fch/dec/exe_enb = 0, mem_enb = wrb_enb = 1; mem_valid <= 0 (bubble), wrb_valid <= mem_valid.
  - dec_stall && dec_valid: fch/dec_enb = 0, exe/mem/wrb_enb = 1; exe_valid <= 0 (bubble); later stages shift.
  - otherwise: all enables 1; dec_valid <= fch_valid, exe_valid <= dec_valid, mem_valid <= exe_valid, wrb_valid <= mem_valid.
- dec_stall, exe_busy and exe_redirect are ignored while their stage valid bit is 0.
- Redirect: exe_redirect && exe_valid && !mem_wait && !exe_busy → fch_redirect = 1 the same cycle, dec_valid <= 0, exe_valid <= 0 (kills the two younger instructions); EXE instruction advances to MEM. Overrides dec_stall.
- Trap: wrb_trap && wrb_valid && !mem_wait → trap_redirect = 1 the same cycle, all valid bits <= 0, FSM → FLUSH. Overrides redirect and all stalls below mem_wait.
- FSM states: RUN (normal), FLUSH (one cycle: all enables 1, all valid bits held 0, fch_valid ignored; → RUN).
- Counters, each +1 per cycle, saturating at 2^CNT_W−1 (no wrap):
  - stall_cnt: any freeze (mem_wait, exe_busy, or dec_stall case) in RUN.
  - load_use_cnt: dec_stall case applied and dec_load_use = 1.
  - csr_use_cnt: dec_stall case applied and dec_csr_use = 1.
  - A trap or redirect cycle increments no counter.

## Timing
- Enables, fch_redirect, trap_redirect: combinational from inputs and current state, same cycle.
- Valid bits, FSM and counters: registered; new value visible the cycle after the event.
- Reset values: all valid bits 0, FSM = RUN, all counters 0; enables follow the RUN rules with all valid bits 0 (all 1 unless mem_wait).
- Reset asserted mid-stall or in FLUSH returns to RUN with valid bits cleared; no pulse outputs during reset.
- Redirect and trap pulses last exactly one cycle per event; a trap held across mem_wait fires once, on the first cycle with mem_wait = 0.

## Structure
- Shared core package: state encoding (RUN, FLUSH) and the stage index constants.
- Sub-module sat_counter (CNT_W, clk, reset, inc, count) instantiated three times; everything else in pipe_ctrl.

## Test plan
- Reset, then fch_valid = 1 for 4 cycles, no hazards → dec/exe/mem/wrb_valid rise on cycles 1/2/3/4; all enables 1; counters 0.
- dec_stall = dec_load_use = 1 for 1 cycle with dec_valid = 1 → fch/dec_enb = 0, exe_valid = 0 next cycle, stall_cnt = 1, load_use_cnt = 1, csr_use_cnt = 0.
- mem_wait = 1 for 3 cycles together with dec_stall and exe_redirect → all enables 0, no valid change, no fch_redirect, stall_cnt = 3.
- exe_redirect with exe_valid = dec_valid = 1 and dec_stall = 1 → fch_redirect pulse one cycle, dec/exe_valid = 0 next cycle, mem_valid = 1, load_use_cnt unchanged.
- wrb_trap with exe_redirect in the same cycle → only trap_redirect pulses; all valid bits 0 for 2 cycles (trap + FLUSH); fch_valid then refills DEC.
- CNT_W = 4, hold mem_wait for 20 cycles → stall_cnt reaches 15 and holds; async reset mid-sequence → counters 0 and valids 0 without a clock edge.
